cd_sram_dp: RTL and testbench



---
 rtl/cd_sram_dp_pkg.sv | 10 +
 rtl/cd_sram_core.sv | 69 ++++++
 rtl/cd_sram_dp.sv | 160 ++++++++++++++++
 tb/tb_cd_sram_dp.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cd_sram_dp_pkg.sv
// Shared types for the cd_sram_dp frame-buffer RAM wrapper.
// Holds the clear-sequencer state encoding.
package cd_sram_dp_pkg;

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RUN = 1'b1
    } clr_state_e;

endpackage

// File: rtl/cd_sram_core.sv
// Simple-dual-port array with registered, read-first read port.
// Latency: 1 cycle read; the read register holds between reads. No backpressure.
// Backpressure: none; one read and one write accepted every cycle.
module cd_sram_core #(
    parameter int A_WIDTH     = 8,
    parameter int D_WIDTH     = 8,
    parameter int C_ASIC_SRAM = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wen,
    input  logic [A_WIDTH-1:0] waddr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic               ren,
    input  logic [A_WIDTH-1:0] raddr,
    output logic [D_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << A_WIDTH;

    logic [D_WIDTH-1:0] rdata_q;
    logic [D_WIDTH-1:0] rdata_d;

    generate
        if (C_ASIC_SRAM != 0) begin : g_macro
            // Behavioural view of the hard macro; the ASIC flow swaps this block for the vendor cell.
            logic [D_WIDTH-1:0] macro_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wen) begin
                    macro_mem[waddr] <= wdata;
                end
            end

            always_comb begin
                rdata_d = rdata_q;
                if (ren) begin
                    rdata_d = macro_mem[raddr];
                end
            end
        end else begin : g_infer
            logic [D_WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wen) begin
                    mem[waddr] <= wdata;
                end
            end

            always_comb begin
                rdata_d = rdata_q;
                if (ren) begin
                    rdata_d = mem[raddr];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cd_sram_dp.sv
// Frame-buffer SRAM wrapper: post-reset clear sequencer, collision handling, read-valid strobe.
// Latency: RD_LAT (1 or 2) cycles from accepted re to rd/rd_vld. Backpressure: none; re/we dropped while busy.
module cd_sram_dp
    import cd_sram_dp_pkg::*;
#(
    parameter int A_WIDTH     = 8,
    parameter int D_WIDTH     = 8,
    parameter int RD_LAT      = 1,
    parameter int BYPASS      = 1,
    parameter int INIT_CLR    = 1,
    parameter int C_ASIC_SRAM = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [A_WIDTH-1:0] ra,
    input  logic               re,
    output logic [D_WIDTH-1:0] rd,
    output logic               rd_vld,
    input  logic [A_WIDTH-1:0] wa,
    input  logic [D_WIDTH-1:0] wd,
    input  logic               we,
    output logic               busy
);

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
            $error("cd_sram_dp: RD_LAT must be 1 or 2");
        end
        if (D_WIDTH < 1 || D_WIDTH > 64) begin : g_bad_d_width
            $error("cd_sram_dp: D_WIDTH must be 1..64");
        end
    endgenerate

    localparam clr_state_e         ST_RESET = (INIT_CLR != 0) ? ST_CLR : ST_RUN;
    localparam logic [A_WIDTH-1:0] CLR_LAST = '1;

    clr_state_e         state_q, state_d;
    logic [A_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RESET;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CLR_LAST) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end
        end
    end

    assign busy = (state_q == ST_CLR);

    logic               rd_acc;
    logic               wr_acc;
    logic               collide;
    logic               mem_wen;
    logic [A_WIDTH-1:0] mem_waddr;
    logic [D_WIDTH-1:0] mem_wdata;
    logic [D_WIDTH-1:0] core_rdata;

    // The clear sequencer owns the write port outright while busy.
    always_comb begin
        rd_acc    = re & ~busy;
        wr_acc    = we & ~busy;
        collide   = rd_acc & wr_acc & (ra == wa);
        mem_wen   = busy | wr_acc;
        mem_waddr = busy ? clr_cnt_q : wa;
        mem_wdata = busy ? '0 : wd;
    end

    cd_sram_core #(
        .A_WIDTH     (A_WIDTH),
        .D_WIDTH     (D_WIDTH),
        .C_ASIC_SRAM (C_ASIC_SRAM)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .wen     (mem_wen),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .ren     (rd_acc),
        .raddr   (ra),
        .rdata   (core_rdata)
    );

    logic               byp_sel_q, byp_sel_d;
    logic [D_WIDTH-1:0] byp_dat_q, byp_dat_d;
    logic               vld1_q, vld1_d;
    logic [D_WIDTH-1:0] rd1;

    // Bypass state only moves on accepted reads so stage-1 data holds like the core register.
    always_comb begin
        byp_sel_d = byp_sel_q;
        byp_dat_d = byp_dat_q;
        vld1_d    = rd_acc;
        if (rd_acc) begin
            byp_sel_d = (BYPASS != 0) && collide;
            if (collide) begin
                byp_dat_d = wd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byp_sel_q <= 1'b0;
            byp_dat_q <= '0;
            vld1_q    <= 1'b0;
        end else begin
            byp_sel_q <= byp_sel_d;
            byp_dat_q <= byp_dat_d;
            vld1_q    <= vld1_d;
        end
    end

    assign rd1 = byp_sel_q ? byp_dat_q : core_rdata;

    generate
        if (RD_LAT == 2) begin : g_stage2
            logic [D_WIDTH-1:0] rd2_q, rd2_d;
            logic               vld2_q, vld2_d;

            always_comb begin
                rd2_d  = rd2_q;
                vld2_d = vld1_q;
                if (vld1_q) begin
                    rd2_d = rd1;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd2_q  <= '0;
                    vld2_q <= 1'b0;
                end else begin
                    rd2_q  <= rd2_d;
                    vld2_q <= vld2_d;
                end
            end

            assign rd     = rd2_q;
            assign rd_vld = vld2_q;
        end else begin : g_stage1
            assign rd     = rd1;
            assign rd_vld = vld1_q;
        end
    endgenerate

endmodule

// File: tb/tb_cd_sram_dp.sv
// Directed bench: u_a is 8-bit/RD_LAT=1/write-through, u_b is 16-bit/RD_LAT=2/read-first, both 16 deep with clear.
module tb_cd_sram_dp;

    logic        clk;
    logic        reset_n;

    logic [3:0]  ra_a, wa_a;
    logic        re_a, we_a, rd_vld_a, busy_a;
    logic [7:0]  wd_a, rd_a;

    logic [3:0]  ra_b, wa_b;
    logic        re_b, we_b, rd_vld_b, busy_b;
    logic [15:0] wd_b, rd_b;

    int n_vec = 0;
    int n_err = 0;

    cd_sram_dp #(
        .A_WIDTH(4), .D_WIDTH(8), .RD_LAT(1), .BYPASS(1), .INIT_CLR(1)
    ) u_a (
        .clk(clk), .reset_n(reset_n),
        .ra(ra_a), .re(re_a), .rd(rd_a), .rd_vld(rd_vld_a),
        .wa(wa_a), .wd(wd_a), .we(we_a), .busy(busy_a)
    );

    cd_sram_dp #(
        .A_WIDTH(4), .D_WIDTH(16), .RD_LAT(2), .BYPASS(0), .INIT_CLR(1)
    ) u_b (
        .clk(clk), .reset_n(reset_n),
        .ra(ra_b), .re(re_b), .rd(rd_b), .rd_vld(rd_vld_b),
        .wa(wa_b), .wd(wd_b), .we(we_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        re_a = 0; we_a = 0; ra_a = 0; wa_a = 0; wd_a = 0;
        re_b = 0; we_b = 0; ra_b = 0; wa_b = 0; wd_b = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (rd_a !== 8'h00) begin n_err++; $display("FAIL reset_rd_a: got %h expected 00", rd_a); end
        n_vec++; if (rd_vld_a !== 1'b0) begin n_err++; $display("FAIL reset_vld_a: got %b expected 0", rd_vld_a); end
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL reset_busy_a: got %b expected 1", busy_a); end
        n_vec++; if (rd_b !== 16'h0000) begin n_err++; $display("FAIL reset_rd_b: got %h expected 0000", rd_b); end
        n_vec++; if (rd_vld_b !== 1'b0) begin n_err++; $display("FAIL reset_vld_b: got %b expected 0", rd_vld_b); end
        n_vec++; if (busy_b !== 1'b1) begin n_err++; $display("FAIL reset_busy_b: got %b expected 1", busy_b); end
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Clear duration, accesses dropped while busy, then every address reads zero.
    task automatic test_clear_and_busy_drop();
        int n = 0;
        while (busy_a === 1'b1 && n < 64) begin
            if (n >= 8 && n < 12) begin
                we_a = 1; wa_a = 4'd2; wd_a = 8'h7F; re_a = 1; ra_a = 4'd2;
            end else begin
                we_a = 0; re_a = 0;
            end
            tick();
            n++;
            n_vec++; if (rd_vld_a !== 1'b0) begin n_err++; $display("FAIL busy_drop_vld cycle %0d: got %b expected 0", n, rd_vld_a); end
        end
        idle_inputs();
        n_vec++; if (n != 16) begin n_err++; $display("FAIL clear_busy_cycles: got %0d expected 16", n); end
        n_vec++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL clear_busy_b_end: got %b expected 0", busy_b); end

        re_a = 1; ra_a = 4'd0;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_vec++; if (rd_vld_a !== 1'b1 || rd_a !== 8'h00) begin
                n_err++; $display("FAIL clear_read addr %0d: got vld=%b rd=%h expected vld=1 rd=00", i, rd_vld_a, rd_a);
            end
            if (i < 15) ra_a = 4'(i + 1);
            else        re_a = 0;
        end
        tick();
        n_vec++; if (rd_vld_a !== 1'b0) begin n_err++; $display("FAIL clear_read_end_vld: got %b expected 0", rd_vld_a); end
    endtask

    task automatic test_basic();
        we_a = 1; wa_a = 4'd3; wd_a = 8'hA5;
        tick();
        we_a = 0; re_a = 1; ra_a = 4'd3;
        n_vec++; if (rd_vld_a !== 1'b0) begin n_err++; $display("FAIL basic_pre_vld: got %b expected 0", rd_vld_a); end
        tick();
        re_a = 0;
        n_vec++; if (rd_vld_a !== 1'b1 || rd_a !== 8'hA5) begin
            n_err++; $display("FAIL basic_read: got vld=%b rd=%h expected vld=1 rd=a5", rd_vld_a, rd_a);
        end
        ra_a = 4'd0;
        tick();
        n_vec++; if (rd_vld_a !== 1'b0 || rd_a !== 8'hA5) begin
            n_err++; $display("FAIL basic_hold1: got vld=%b rd=%h expected vld=0 rd=a5", rd_vld_a, rd_a);
        end
        tick();
        n_vec++; if (rd_a !== 8'hA5) begin n_err++; $display("FAIL basic_hold2: got %h expected a5", rd_a); end
    endtask

    task automatic test_latency2();
        logic [15:0] exp_dat [4];
        exp_dat[0] = 16'h1111; exp_dat[1] = 16'h2222; exp_dat[2] = 16'h3333; exp_dat[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            we_b = 1; wa_b = 4'(i); wd_b = exp_dat[i];
            tick();
        end
        we_b = 0;
        re_b = 1; ra_b = 4'd0;
        tick();
        n_vec++; if (rd_vld_b !== 1'b0) begin n_err++; $display("FAIL lat2_first_cycle_vld: got %b expected 0", rd_vld_b); end
        ra_b = 4'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (rd_vld_b !== 1'b1 || rd_b !== exp_dat[i]) begin
                n_err++; $display("FAIL lat2_read %0d: got vld=%b rd=%h expected vld=1 rd=%h", i, rd_vld_b, rd_b, exp_dat[i]);
            end
            if (i < 2) ra_b = 4'(i + 2);
            else       re_b = 0;
        end
        tick();
        n_vec++; if (rd_vld_b !== 1'b0 || rd_b !== 16'h4444) begin
            n_err++; $display("FAIL lat2_hold: got vld=%b rd=%h expected vld=0 rd=4444", rd_vld_b, rd_b);
        end
    endtask

    task automatic test_collision_bypass();
        we_a = 1; wa_a = 4'd5; wd_a = 8'h11;
        tick();
        wd_a = 8'h22; re_a = 1; ra_a = 4'd5;
        tick();
        we_a = 0;
        n_vec++; if (rd_vld_a !== 1'b1 || rd_a !== 8'h22) begin
            n_err++; $display("FAIL coll_bypass: got vld=%b rd=%h expected vld=1 rd=22", rd_vld_a, rd_a);
        end
        tick();
        re_a = 0;
        n_vec++; if (rd_vld_a !== 1'b1 || rd_a !== 8'h22) begin
            n_err++; $display("FAIL coll_bypass_next: got vld=%b rd=%h expected vld=1 rd=22", rd_vld_a, rd_a);
        end
    endtask

    task automatic test_collision_read_first();
        we_b = 1; wa_b = 4'd5; wd_b = 16'h0011;
        tick();
        wd_b = 16'h0022; re_b = 1; ra_b = 4'd5;
        tick();
        we_b = 0;
        tick();
        re_b = 0;
        n_vec++; if (rd_vld_b !== 1'b1 || rd_b !== 16'h0011) begin
            n_err++; $display("FAIL coll_read_first: got vld=%b rd=%h expected vld=1 rd=0011", rd_vld_b, rd_b);
        end
        tick();
        n_vec++; if (rd_vld_b !== 1'b1 || rd_b !== 16'h0022) begin
            n_err++; $display("FAIL coll_read_first_next: got vld=%b rd=%h expected vld=1 rd=0022", rd_vld_b, rd_b);
        end
        tick();
        n_vec++; if (rd_vld_b !== 1'b0) begin n_err++; $display("FAIL coll_read_first_end: got %b expected 0", rd_vld_b); end
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        // Launch a read into u_b's pipeline and dirty address 14 of u_a, then reset under them.
        re_b = 1; ra_b = 4'd5;
        we_a = 1; wa_a = 4'd14; wd_a = 8'h5A;
        tick();
        reset_n = 1'b0;
        idle_inputs();
        #1;
        n_vec++; if (rd_a !== 8'h00 || rd_vld_a !== 1'b0) begin
            n_err++; $display("FAIL rst_flush_a: got vld=%b rd=%h expected vld=0 rd=00", rd_vld_a, rd_a);
        end
        n_vec++; if (rd_b !== 16'h0000 || rd_vld_b !== 1'b0) begin
            n_err++; $display("FAIL rst_flush_b: got vld=%b rd=%h expected vld=0 rd=0000", rd_vld_b, rd_b);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_vec++; if (rd_vld_b !== 1'b0 || busy_a !== 1'b1) begin
                n_err++; $display("FAIL rst_first_clear cycle %0d: got vld_b=%b busy_a=%b expected 0 1", i, rd_vld_b, busy_a);
            end
        end
        reset_n = 1'b0;
        #1;
        n_vec++; if (rd_a !== 8'h00 || rd_vld_a !== 1'b0 || busy_a !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_clear_a: got vld=%b rd=%h busy=%b expected 0 00 1", rd_vld_a, rd_a, busy_a);
        end
        n_vec++; if (rd_b !== 16'h0000 || rd_vld_b !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_clear_b: got vld=%b rd=%h expected 0 0000", rd_vld_b, rd_b);
        end
        tick();
        reset_n = 1'b1;
        while (busy_a === 1'b1 && n < 64) begin
            tick();
            n++;
        end
        n_vec++; if (n != 16) begin n_err++; $display("FAIL rst_restart_busy_cycles: got %0d expected 16", n); end
        re_a = 1; ra_a = 4'd14;
        tick();
        re_a = 0;
        n_vec++; if (rd_vld_a !== 1'b1 || rd_a !== 8'h00) begin
            n_err++; $display("FAIL rst_restart_cleared: got vld=%b rd=%h expected vld=1 rd=00", rd_vld_a, rd_a);
        end
    endtask

    initial begin
        test_reset();
        test_clear_and_busy_drop();
        test_basic();
        test_latency2();
        test_collision_bypass();
        test_collision_read_first();
        test_reset_mid_clear();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
